cam_axi_wr_dma: RTL and testbench

Camera-to-memory write DMA for the CNN accelerator. It takes the 8-bit camera byte stream after clock-domain crossing into `clk` and packs the bytes into DATA_WIDTH words. It buffers the words in an internal FIFO and writes each frame to external memory as AXI3 INCR write bursts starting at a programmable base address. It sits between the camera capture front end and the accelerator's memory/AXI interconnect, and signals frame completion to the controller.

---
 rtl/cam_axi_wr_dma.sv | 214 +++++++++++++++++++++
 tb/tb_cam_axi_wr_dma.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_axi_wr_dma.sv
// Camera byte stream to AXI3 write DMA: packs bytes into little-endian words,
// buffers them in a show-ahead FIFO and writes each frame as INCR bursts.
module cam_axi_wr_dma #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_MAX_WIDTH = 4,
  parameter int AXI_ID       = 0,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic                      i_sof,
  input  logic                      i_valid,
  input  logic [7:0]                i_data,
  input  logic                      i_eof,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_frame_drop,
  output logic                      o_overflow,
  output logic                      o_err,
  output logic [ID_MAX_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0]     awaddr,
  output logic [3:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [ID_MAX_WIDTH-1:0]   bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int BPW    = DATA_WIDTH / 8;
  localparam int IW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int FAW    = $clog2(FIFO_DEPTH);
  localparam int CW     = FAW + 1;
  localparam int NW     = 5;
  localparam logic [2:0] AXSIZE = 3'($clog2(BPW));

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                  state;
  logic [NW-1:0]           burst_n;
  logic [NW-1:0]           beat_cnt;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    flush_pending;

  logic [IW-1:0]           byte_idx;
  logic [DATA_WIDTH-1:0]   pack_data;
  logic [BPW-1:0]          pack_strb;
  logic [DATA_WIDTH-1:0]   word_data;
  logic [BPW-1:0]          word_strb;

  logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [BPW-1:0]          fifo_strb [FIFO_DEPTH];
  logic [CW-1:0]           wr_ptr;
  logic [CW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic sof_acc, byte_acc, push, pop, full, wr_en;
  logic unused_bid;

  always_comb begin
    sof_acc   = i_sof && !o_busy;
    byte_acc  = i_valid && o_busy && !flush_pending;
    word_data = pack_data | (DATA_WIDTH'(i_data) << {byte_idx, 3'b000});
    word_strb = pack_strb | (BPW'(1) << byte_idx);
    push      = byte_acc && (i_eof || byte_idx == IW'(BPW - 1));
    pop       = wvalid && wready;
    count     = wr_ptr - rd_ptr;
    full      = (count == CW'(FIFO_DEPTH));
    wr_en     = push && (!full || pop);
  end

  assign wdata      = wvalid ? fifo_data[rd_ptr[FAW-1:0]] : '0;
  assign wstrb      = wvalid ? fifo_strb[rd_ptr[FAW-1:0]] : '0;
  assign awsize     = awvalid ? AXSIZE : 3'b000;
  assign awburst    = awvalid ? 2'b01 : 2'b00;
  assign awid       = awvalid ? ID_MAX_WIDTH'(AXI_ID) : '0;
  assign unused_bid = ^bid;

  // Packer stage: a word leaves on its last byte or on the eof byte
  always_ff @(posedge clk) begin
    if (!rst_n || sof_acc) begin
      byte_idx  <= '0;
      pack_data <= '0;
      pack_strb <= '0;
    end else if (byte_acc) begin
      if (push) begin
        byte_idx  <= '0;
        pack_data <= '0;
        pack_strb <= '0;
      end else begin
        byte_idx  <= byte_idx + IW'(1);
        pack_data <= word_data;
        pack_strb <= word_strb;
      end
    end
  end

  // FIFO stage
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data[wr_ptr[FAW-1:0]] <= word_data;
      fifo_strb[wr_ptr[FAW-1:0]] <= word_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || sof_acc) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + CW'(1);
      if (pop)   rd_ptr <= rd_ptr + CW'(1);
      if (push && !wr_en) o_overflow <= 1'b1;
    end
  end

  // Burst stage: burst_n is frozen for the whole AW/W/B sequence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      burst_n       <= '0;
      beat_cnt      <= '0;
      cur_addr      <= '0;
      flush_pending <= 1'b0;
      awvalid       <= 1'b0;
      awaddr        <= '0;
      awlen         <= '0;
      wvalid        <= 1'b0;
      wlast         <= 1'b0;
      bready        <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_drop  <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_frame_drop <= i_sof && o_busy;
      if (sof_acc) begin
        cur_addr      <= i_base_addr;
        o_busy        <= 1'b1;
        o_err         <= 1'b0;
        flush_pending <= 1'b0;
      end
      if (byte_acc && i_eof) flush_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (o_busy) begin
            if (count >= CW'(BURST_LEN)) begin
              burst_n <= NW'(BURST_LEN);
              awlen   <= 4'(BURST_LEN - 1);
              awaddr  <= cur_addr;
              awvalid <= 1'b1;
              state   <= S_AW;
            end else if (flush_pending && count != '0) begin
              burst_n <= NW'(count);
              awlen   <= 4'(count - CW'(1));
              awaddr  <= cur_addr;
              awvalid <= 1'b1;
              state   <= S_AW;
            end else if (flush_pending && byte_idx == '0) begin
              o_frame_done  <= 1'b1;
              o_busy        <= 1'b0;
              flush_pending <= 1'b0;
            end
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid  <= 1'b0;
            wvalid   <= 1'b1;
            wlast    <= (burst_n == NW'(1));
            beat_cnt <= '0;
            state    <= S_W;
          end
        end
        S_W: begin
          if (wready) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              beat_cnt <= beat_cnt + NW'(1);
              wlast    <= (beat_cnt + NW'(2) == burst_n);
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            bready   <= 1'b0;
            if (bresp != 2'b00) o_err <= 1'b1;
            cur_addr <= cur_addr + (ADDR_WIDTH'(burst_n) << AXSIZE);
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_axi_wr_dma.sv
// Directed bench for cam_axi_wr_dma: streams frames and acts as the AXI slave.
module tb_cam_axi_wr_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_base_addr;
  logic        i_sof, i_valid, i_eof;
  logic [7:0]  i_data;
  logic        o_busy, o_frame_done, o_frame_drop, o_overflow, o_err;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  cam_axi_wr_dma dut (
    .clk(clk), .rst_n(rst_n), .i_base_addr(i_base_addr), .i_sof(i_sof),
    .i_valid(i_valid), .i_data(i_data), .i_eof(i_eof), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frame_drop(o_frame_drop),
    .o_overflow(o_overflow), .o_err(o_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt, drop_cnt;
  bit w_hold;
  logic [31:0] aw_addr_q [$];
  logic [3:0]  aw_len_q  [$];
  logic [63:0] w_data_q  [$];
  logic [7:0]  w_strb_q  [$];
  logic        w_last_q  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({awvalid, wvalid, bready, wlast, o_busy, o_frame_done,
                             o_frame_drop, o_overflow, o_err, awlen, awsize, awburst, awid}), 64'd0);
    chk({tag, "_awaddr"}, 64'(awaddr), 64'd0);
    chk({tag, "_wdata"}, wdata, 64'd0);
    chk({tag, "_wstrb"}, 64'(wstrb), 64'd0);
  endtask

  function automatic bit rnd_ready();
    return $urandom_range(0, 9) < 6;
  endfunction

  task automatic run_frame(input logic [31:0] base, input int nbytes, input bit rnd,
                           input bit hold, input bit bad_first, input int mid);
    aw_addr_q.delete(); aw_len_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_last_q.delete();
    done_cnt = 0; drop_cnt = 0; w_hold = hold;
    fork
      begin
        @(negedge clk); i_base_addr = base; i_sof = 1'b1;
        @(negedge clk); i_sof = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
          @(negedge clk);
          if (hold && i == 256) chk("ovf_at_fifo_full", 64'(o_overflow), 64'd0);
          if (hold && i == 264) chk("ovf_after_drop", 64'(o_overflow), 64'd1);
          i_valid     = 1'b1;
          i_data      = 8'(i);
          i_eof       = (i == nbytes - 1);
          i_sof       = (i == mid);
          i_base_addr = (i == mid) ? 32'hDEAD_0000 : base;
        end
        @(negedge clk); i_valid = 1'b0; i_eof = 1'b0; i_sof = 1'b0;
        repeat (4) @(negedge clk);
        w_hold = 1'b0;
      end
      begin
        int pend_b, b_idx, tail;
        logic p_awv, p_awr, p_wv, p_wr, p_wlast;
        logic [31:0] p_awaddr;
        logic [3:0]  p_awlen;
        logic [63:0] p_wdata;
        logic [7:0]  p_wstrb;
        pend_b = 0; b_idx = 0; tail = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_wlast = 0;
        p_awaddr = '0; p_awlen = '0; p_wdata = '0; p_wstrb = '0;
        for (int c = 0; c < 3000 && tail < 5; c++) begin
          @(negedge clk);
          if (o_frame_done) done_cnt++;
          if (o_frame_drop) drop_cnt++;
          if (done_cnt > 0) tail++;
          if (p_awv && !p_awr) begin
            chk("aw_stall_valid", 64'(awvalid), 64'd1);
            chk("aw_stall_addr", 64'(awaddr), 64'(p_awaddr));
            chk("aw_stall_len", 64'(awlen), 64'(p_awlen));
          end
          if (p_wv && !p_wr) begin
            chk("w_stall_valid", 64'(wvalid), 64'd1);
            chk("w_stall_data", wdata, p_wdata);
            chk("w_stall_strb", 64'(wstrb), 64'(p_wstrb));
            chk("w_stall_last", 64'(wlast), 64'(p_wlast));
          end
          awready = rnd ? rnd_ready() : 1'b1;
          wready  = w_hold ? 1'b0 : (rnd ? rnd_ready() : 1'b1);
          bvalid  = (pend_b > 0) && (rnd ? rnd_ready() : 1'b1);
          bresp   = (bad_first && b_idx == 0) ? 2'b10 : 2'b00;
          if (bvalid && bready) begin pend_b--; b_idx++; end
          if (awvalid && awready) begin
            aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen);
          end
          if (wvalid && wready) begin
            w_data_q.push_back(wdata); w_strb_q.push_back(wstrb); w_last_q.push_back(wlast);
            if (wlast) pend_b++;
          end
          p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awlen = awlen;
          p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast;
        end
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
      end
    join
  endtask

  task automatic check_frame(input string tag, input logic [31:0] base, input int nbytes,
                             input bit hold);
    int nw, kept, nb;
    logic [63:0] ed;
    logic [7:0]  es;
    nw   = (nbytes + 7) / 8;
    kept = (hold && nw > 32) ? 32 : nw;
    nb   = (kept + 15) / 16;
    chk({tag, "_aw_count"}, 64'(aw_addr_q.size()), 64'(nb));
    for (int k = 0; k < nb && k < aw_addr_q.size(); k++) begin
      chk($sformatf("%s_awaddr[%0d]", tag, k), 64'(aw_addr_q[k]), 64'(base + 32'(k * 128)));
      chk($sformatf("%s_awlen[%0d]", tag, k), 64'(aw_len_q[k]),
          64'((k == nb - 1) ? (kept - 16 * k - 1) : 15));
    end
    chk({tag, "_beat_count"}, 64'(w_data_q.size()), 64'(kept));
    for (int j = 0; j < kept && j < w_data_q.size(); j++) begin
      ed = '0; es = '0;
      for (int b = 0; b < 8; b++) begin
        if (8 * j + b < nbytes) begin
          ed[8*b +: 8] = 8'(8 * j + b);
          es[b] = 1'b1;
        end
      end
      chk($sformatf("%s_wdata[%0d]", tag, j), w_data_q[j], ed);
      chk($sformatf("%s_wstrb[%0d]", tag, j), 64'(w_strb_q[j]), 64'(es));
      chk($sformatf("%s_wlast[%0d]", tag, j), 64'(w_last_q[j]),
          64'((j % 16 == 15) || (j == kept - 1)));
    end
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    int beats;
    bit fired;
    rst_n = 1'b0; i_base_addr = '0; i_sof = 0; i_valid = 0; i_eof = 0; i_data = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    w_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(32'h1000_0000, 256, 1'b0, 1'b0, 1'b0, -1);
    check_frame("full", 32'h1000_0000, 256, 1'b0);
    chk("full_aw0", 64'(aw_addr_q[0]), 64'h1000_0000);
    chk("full_len0", 64'(aw_len_q[0]), 64'd15);
    chk("full_aw1", 64'(aw_addr_q[1]), 64'h1000_0080);
    chk("full_len1", 64'(aw_len_q[1]), 64'd15);
    chk("full_wdata0", w_data_q[0], 64'h0706050403020100);
    chk("full_wstrb0", 64'(w_strb_q[0]), 64'hFF);

    run_frame(32'h1000_0000, 131, 1'b0, 1'b0, 1'b0, -1);
    check_frame("tail", 32'h1000_0000, 131, 1'b0);
    chk("tail_aw1", 64'(aw_addr_q[1]), 64'h1000_0080);
    chk("tail_len1", 64'(aw_len_q[1]), 64'd0);
    chk("tail_wdata", w_data_q[16], 64'h0000_0000_0082_8180);
    chk("tail_wstrb", 64'(w_strb_q[16]), 64'h07);
    chk("tail_wlast", 64'(w_last_q[16]), 64'd1);

    run_frame(32'h4000_0000, 200, 1'b1, 1'b0, 1'b0, -1);
    check_frame("stall", 32'h4000_0000, 200, 1'b0);

    run_frame(32'h5000_0000, 300, 1'b0, 1'b1, 1'b0, -1);
    check_frame("ovf", 32'h5000_0000, 300, 1'b1);
    chk("ovf_sticky", 64'(o_overflow), 64'd1);

    run_frame(32'h6000_0000, 256, 1'b0, 1'b0, 1'b1, -1);
    check_frame("bresp", 32'h6000_0000, 256, 1'b0);
    chk("ovf_cleared_by_sof", 64'(o_overflow), 64'd0);
    chk("err_sticky", 64'(o_err), 64'd1);
    chk("bresp_aw1", 64'(aw_addr_q[1]), 64'h6000_0080);

    run_frame(32'h7000_0000, 200, 1'b0, 1'b0, 1'b0, 50);
    check_frame("midsof", 32'h7000_0000, 200, 1'b0);
    chk("midsof_drop_count", 64'(drop_cnt), 64'd1);
    chk("midsof_err_cleared", 64'(o_err), 64'd0);
    chk("midsof_aw0", 64'(aw_addr_q[0]), 64'h7000_0000);

    @(negedge clk); i_base_addr = 32'h3000_0000; i_sof = 1'b1;
    @(negedge clk); i_sof = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk); i_valid = 1'b1; i_data = 8'(i); i_eof = 1'b0;
    end
    @(negedge clk); i_valid = 1'b0;
    beats = 0; fired = 1'b0;
    for (int c = 0; c < 100 && !fired; c++) begin
      @(negedge clk);
      if (wvalid && wready) begin
        beats++;
        if (beats == 5) begin
          rst_n = 1'b0;
          fired = 1'b1;
        end
      end
    end
    chk("rst_mid_reached_beat5", 64'(fired), 64'd1);
    @(negedge clk);
    chk_outputs_zero("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(32'h2000_0000, 128, 1'b0, 1'b0, 1'b0, -1);
    check_frame("post_rst", 32'h2000_0000, 128, 1'b0);
    chk("post_rst_aw0", 64'(aw_addr_q[0]), 64'h2000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
